// File: rtl/pipe_reg_pkg.sv
// Shared constants and helpers for the pipe_reg valid/ready register pipeline.
package pipe_reg_pkg;

  localparam int unsigned DEF_WIDTH  = 8;
  localparam int unsigned DEF_STAGES = 3;

  // Bits needed to count 0..stages valid entries.
  function automatic int unsigned occ_width(input int unsigned stages);
    return $clog2(stages + 1);
  endfunction

endpackage

// File: rtl/pipe_reg_stage.sv
// One pipeline slot: valid bit plus enable-gated data register, sync active-low reset and flush.
module pipe_reg_stage #(
  parameter int unsigned       WIDTH     = 8,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             en,
  input  logic             ld,
  input  logic             v_in,
  input  logic [WIDTH-1:0] d_in,
  output logic             v,
  output logic [WIDTH-1:0] d
);

  // Data only moves with a valid message so an emptied slot keeps its last value.
  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      v <= 1'b0;
      d <= RESET_VAL;
    end else begin
      if (en) v <= v_in;
      if (ld) d <= d_in;
    end
  end

endmodule

// File: rtl/pipe_reg.sv
// Bubble-collapsing valid/ready register pipeline of STAGES slots.
// Optional occupancy counter output enabled by defining PIPE_REG_OCC_EN.
module pipe_reg
  import pipe_reg_pkg::*;
#(
  parameter int unsigned      WIDTH     = DEF_WIDTH,
  parameter int unsigned      STAGES    = DEF_STAGES,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_val,
  output logic             in_rdy,
  input  logic [WIDTH-1:0] in_msg,
  output logic             out_val,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] out_msg
`ifdef PIPE_REG_OCC_EN
  ,
  output logic [occ_width(STAGES)-1:0] occ
`endif
);

  logic [STAGES-1:0] v;
  logic [WIDTH-1:0]  d [STAGES];
  logic [STAGES-1:0] rdy;

  // A slot can load when it or any slot downstream of it is empty, or the tail drains.
  always_comb begin
    logic acc;
    rdy = '0;
    acc = out_rdy;
    for (int i = int'(STAGES) - 1; i >= 0; i--) begin
      acc    = acc | !v[i];
      rdy[i] = acc;
    end
  end

  for (genvar i = 0; i < int'(STAGES); i++) begin : g_stage
    logic             v_in;
    logic             ld;
    logic [WIDTH-1:0] d_in;
    if (i == 0) begin : g_head
      assign v_in = in_val;
      assign d_in = in_msg;
    end else begin : g_body
      assign v_in = v[i-1];
      assign d_in = d[i-1];
    end
    assign ld = rdy[i] & v_in;

    pipe_reg_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk   (clk),
      .reset (reset),
      .flush (flush),
      .en    (rdy[i]),
      .ld    (ld),
      .v_in  (v_in),
      .d_in  (d_in),
      .v     (v[i]),
      .d     (d[i])
    );
  end

  // Flush and reset block both handshakes so nothing is reported as transferred.
  assign in_rdy  = rdy[0] & !flush & reset;
  assign out_val = v[STAGES-1] & !flush & reset;
  assign out_msg = d[STAGES-1];

`ifdef PIPE_REG_OCC_EN
  localparam int unsigned OCC_W = occ_width(STAGES);

  logic enq;
  logic deq;
  assign enq = in_val & in_rdy;
  assign deq = out_val & out_rdy;

  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      occ <= '0;
    end else if (enq && !deq) begin
      occ <= occ + OCC_W'(1);
    end else if (deq && !enq) begin
      occ <= occ - OCC_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_reg.sv
// Directed bench for pipe_reg (3-stage instance) plus a randomized 1-stage scoreboard run.
module tb_pipe_reg;

  logic       clk;
  logic       reset, flush, in_val, out_rdy;
  logic [7:0] in_msg;
  logic       in_rdy, out_val;
  logic [7:0] out_msg;

  logic       reset1, flush1, in_val1, out_rdy1;
  logic [7:0] in_msg1;
  logic       in_rdy1, out_val1;
  logic [7:0] out_msg1;

`ifdef PIPE_REG_OCC_EN
  logic [1:0] occ;
  logic [0:0] occ1;
`endif

  int checks = 0;
  int errors = 0;

  pipe_reg #(.WIDTH(8), .STAGES(3), .RESET_VAL(8'h00)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_val(in_val), .in_rdy(in_rdy), .in_msg(in_msg),
    .out_val(out_val), .out_rdy(out_rdy), .out_msg(out_msg)
`ifdef PIPE_REG_OCC_EN
    , .occ(occ)
`endif
  );

  pipe_reg #(.WIDTH(8), .STAGES(1), .RESET_VAL(8'hFF)) dut1 (
    .clk(clk), .reset(reset1), .flush(flush1),
    .in_val(in_val1), .in_rdy(in_rdy1), .in_msg(in_msg1),
    .out_val(out_val1), .out_rdy(out_rdy1), .out_msg(out_msg1)
`ifdef PIPE_REG_OCC_EN
    , .occ(occ1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0; flush = 1'b0; in_val = 1'b0; in_msg = 8'h00; out_rdy = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (in_rdy !== 1'b0) begin errors++; $display("FAIL reset_in_rdy_low: got %b want 0", in_rdy); end
    next_cycle();
    next_cycle();
    reset = 1'b1;
    #1;
    checks++;
    if (out_val !== 1'b0) begin errors++; $display("FAIL reset_out_val: got %b want 0", out_val); end
    checks++;
    if (out_msg !== 8'h00) begin errors++; $display("FAIL reset_out_msg: got %h want 00", out_msg); end
    checks++;
    if (in_rdy !== 1'b1) begin errors++; $display("FAIL reset_in_rdy: got %b want 1", in_rdy); end
`ifdef PIPE_REG_OCC_EN
    checks++;
    if (occ !== 2'd0) begin errors++; $display("FAIL reset_occ: got %0d want 0", occ); end
`endif
  endtask

  task automatic test_streaming();
    logic [7:0] msgs [3];
    logic [1:0] exp_occ [8];
    msgs[0] = 8'h11; msgs[1] = 8'h22; msgs[2] = 8'h33;
    exp_occ = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0, 2'd0};
    out_rdy = 1'b1;
    for (int c = 0; c < 8; c++) begin
      in_val = (c < 3);
      in_msg = (c < 3) ? msgs[c] : 8'hEE;
      #1;
      if (c < 3) begin
        checks++;
        if (in_rdy !== 1'b1) begin errors++; $display("FAIL stream_in_rdy c%0d: got %b want 1", c, in_rdy); end
      end
      checks++;
      if (out_val !== (c >= 3 && c <= 5)) begin
        errors++; $display("FAIL stream_out_val c%0d: got %b want %b", c, out_val, (c >= 3 && c <= 5));
      end
      if (c >= 3 && c <= 5) begin
        checks++;
        if (out_msg !== msgs[c-3]) begin errors++; $display("FAIL stream_out_msg c%0d: got %h want %h", c, out_msg, msgs[c-3]); end
      end
      if (c >= 6) begin
        checks++;
        if (out_msg !== 8'h33) begin errors++; $display("FAIL stream_hold_msg c%0d: got %h want 33", c, out_msg); end
      end
`ifdef PIPE_REG_OCC_EN
      checks++;
      if (occ !== exp_occ[c]) begin errors++; $display("FAIL stream_occ c%0d: got %0d want %0d", c, occ, exp_occ[c]); end
`endif
      next_cycle();
    end
  endtask

  task automatic test_backpressure();
    out_rdy = 1'b0;
    for (int c = 0; c < 3; c++) begin
      in_val = 1'b1; in_msg = 8'hB1 + 8'(c);
      #1;
      checks++;
      if (in_rdy !== 1'b1) begin errors++; $display("FAIL bp_accept c%0d: got %b want 1", c, in_rdy); end
      next_cycle();
    end
    in_val = 1'b1; in_msg = 8'hB4;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (in_rdy !== 1'b0) begin errors++; $display("FAIL bp_full_in_rdy c%0d: got %b want 0", c, in_rdy); end
      checks++;
      if (out_val !== 1'b1 || out_msg !== 8'hB1) begin
        errors++; $display("FAIL bp_full_head c%0d: got %b/%h want 1/b1", c, out_val, out_msg);
      end
`ifdef PIPE_REG_OCC_EN
      checks++;
      if (occ !== 2'd3) begin errors++; $display("FAIL bp_full_occ c%0d: got %0d want 3", c, occ); end
`endif
      next_cycle();
    end
    out_rdy = 1'b1;
    #1;
    checks++;
    if (in_rdy !== 1'b1) begin errors++; $display("FAIL bp_release_in_rdy: got %b want 1", in_rdy); end
    checks++;
    if (out_val !== 1'b1 || out_msg !== 8'hB1) begin
      errors++; $display("FAIL bp_release_head: got %b/%h want 1/b1", out_val, out_msg);
    end
    next_cycle();
    in_val = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (out_val !== (c < 3)) begin errors++; $display("FAIL bp_drain_val c%0d: got %b want %b", c, out_val, (c < 3)); end
      if (c < 3) begin
        checks++;
        if (out_msg !== 8'hB2 + 8'(c)) begin errors++; $display("FAIL bp_drain_msg c%0d: got %h want %h", c, out_msg, 8'hB2 + 8'(c)); end
      end
`ifdef PIPE_REG_OCC_EN
      if (c == 0) begin
        checks++;
        if (occ !== 2'd3) begin errors++; $display("FAIL bp_both_occ: got %0d want 3", occ); end
      end
`endif
      next_cycle();
    end
  endtask

  task automatic test_flush();
    out_rdy = 1'b0;
    for (int c = 0; c < 3; c++) begin
      in_val = 1'b1; in_msg = 8'hA1 + 8'(c);
      next_cycle();
    end
    flush = 1'b1; in_val = 1'b1; in_msg = 8'h55; out_rdy = 1'b1;
    #1;
    checks++;
    if (out_val !== 1'b0) begin errors++; $display("FAIL flush_out_val: got %b want 0", out_val); end
    checks++;
    if (in_rdy !== 1'b0) begin errors++; $display("FAIL flush_in_rdy: got %b want 0", in_rdy); end
    next_cycle();
    flush = 1'b0; in_val = 1'b1; in_msg = 8'h5A;
    #1;
    checks++;
    if (out_val !== 1'b0 || out_msg !== 8'h00) begin
      errors++; $display("FAIL flush_after: got %b/%h want 0/00", out_val, out_msg);
    end
`ifdef PIPE_REG_OCC_EN
    checks++;
    if (occ !== 2'd0) begin errors++; $display("FAIL flush_occ: got %0d want 0", occ); end
`endif
    next_cycle();
    in_val = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      #1;
      checks++;
      if (out_val !== (c == 3)) begin errors++; $display("FAIL flush_latency c%0d: got %b want %b", c, out_val, (c == 3)); end
      if (c == 3) begin
        checks++;
        if (out_msg !== 8'h5A) begin errors++; $display("FAIL flush_latency_msg: got %h want 5a", out_msg); end
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_mid();
    out_rdy = 1'b1;
    for (int c = 0; c < 2; c++) begin
      in_val = 1'b1; in_msg = 8'hC1 + 8'(c);
      next_cycle();
    end
    in_val = 1'b0; reset = 1'b0;
    #1;
    checks++;
    if (in_rdy !== 1'b0 || out_val !== 1'b0) begin
      errors++; $display("FAIL rstmid_during: got in_rdy=%b out_val=%b want 0/0", in_rdy, out_val);
    end
    next_cycle();
    reset = 1'b1;
    #1;
    checks++;
    if (out_val !== 1'b0 || out_msg !== 8'h00 || in_rdy !== 1'b1) begin
      errors++; $display("FAIL rstmid_after: got %b/%h/%b want 0/00/1", out_val, out_msg, in_rdy);
    end
`ifdef PIPE_REG_OCC_EN
    checks++;
    if (occ !== 2'd0) begin errors++; $display("FAIL rstmid_occ: got %0d want 0", occ); end
`endif
    for (int c = 0; c < 5; c++) begin
      next_cycle();
      checks++;
      if (out_val !== 1'b0) begin errors++; $display("FAIL rstmid_stale c%0d: got %b want 0", c, out_val); end
    end
  endtask

  task automatic test_single_random();
    logic [7:0] q [$];
    logic [7:0] exp_msg;
    int         sb_err;
    sb_err = 0;
    reset1 = 1'b0; flush1 = 1'b0; in_val1 = 1'b0; in_msg1 = 8'h00; out_rdy1 = 1'b0;
    next_cycle();
    next_cycle();
    reset1 = 1'b1;
    #1;
    checks++;
    if (out_val1 !== 1'b0 || out_msg1 !== 8'hFF || in_rdy1 !== 1'b1) begin
      errors++; $display("FAIL s1_reset: got %b/%h/%b want 0/ff/1", out_val1, out_msg1, in_rdy1);
    end
    next_cycle();
    for (int c = 0; c < 1000; c++) begin
      in_val1  = 1'($urandom_range(0, 1));
      in_msg1  = 8'($urandom_range(0, 255));
      out_rdy1 = 1'($urandom_range(0, 1));
      #1;
      checks++;
      if (out_val1 !== (q.size() != 0) || in_rdy1 !== (q.size() == 0 || out_rdy1)) begin
        errors++;
        if (sb_err < 5) $display("FAIL s1_hs c%0d: got val=%b rdy=%b want val=%b rdy=%b",
                                 c, out_val1, in_rdy1, (q.size() != 0), (q.size() == 0 || out_rdy1));
        sb_err++;
      end
      if (out_val1 && out_rdy1 && q.size() != 0) begin
        exp_msg = q.pop_front();
        checks++;
        if (out_msg1 !== exp_msg) begin
          errors++;
          if (sb_err < 5) $display("FAIL s1_order c%0d: got %h want %h", c, out_msg1, exp_msg);
          sb_err++;
        end
      end
      if (in_val1 && in_rdy1) q.push_back(in_msg1);
      next_cycle();
    end
    in_val1 = 1'b0; out_rdy1 = 1'b1;
    next_cycle();
    next_cycle();
    checks++;
    if (out_val1 !== 1'b0) begin errors++; $display("FAIL s1_drain: got %b want 0 (queue %0d)", out_val1, q.size()); end
  endtask

  initial begin
    reset1 = 1'b0; flush1 = 1'b0; in_val1 = 1'b0; in_msg1 = 8'h00; out_rdy1 = 1'b0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_single_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_reg.md
PIPE_REG -- requirements
Module: pipe_reg

Interface
REQ-001 Parameter WIDTH, default 8, payload width in bits (>=1).
REQ-002 Parameter STAGES, default 3, number of register stages (>=1).
REQ-003 Parameter RESET_VAL, default 0, WIDTH-bit value loaded into every data register on reset and flush.
REQ-004 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port reset  input  1  synchronous, active-low reset (0 = reset, sampled at posedge clk).
REQ-006 Port flush  input  1  synchronous clear of all stage contents.
REQ-007 Port in_val  input  1  upstream message valid.
REQ-008 Port in_rdy  output  1  pipe accepts a message this cycle.
REQ-009 Port in_msg  input  WIDTH  upstream payload.
REQ-010 Port out_val  output  1  stage STAGES-1 holds a valid message.
REQ-011 Port out_rdy  input  1  downstream accepts this cycle.
REQ-012 Port out_msg  output  WIDTH  payload of stage STAGES-1.

Function
REQ-013 Transfer occurs on a port only when its val and rdy are both 1 at the posedge.
REQ-014 Each stage i holds valid bit v[i] and data d[i]; stage 0 is input side, stage STAGES-1 is output side.
REQ-015 Stage i SHALL load from its predecessor (or in_msg for i=0) when it is empty or its own content leaves this cycle (bubble collapsing).
REQ-016 Ready chain is combinational: rdy[STAGES-1] = !v[STAGES-1] | out_rdy; rdy[i] = !v[i] | rdy[i+1]; in_rdy = rdy[0] & !flush.
REQ-017 Latency with out_rdy held 1: message accepted in cycle t appears with out_val=1 in cycle t+STAGES.
REQ-018 Throughput: one message per cycle sustained when out_rdy is held 1.
REQ-019 Stage holding a valid message whose successor cannot accept SHALL keep d[i] unchanged (enable-gated register).
REQ-020 Messages exit in acceptance order; none duplicated or dropped except by flush/reset.
REQ-021 Full (all v=1) with out_rdy=0: in_rdy=0; full with out_rdy=1: in_rdy=1 and simultaneous dequeue/enqueue both occur.
REQ-022 Empty: out_val=0; out_msg equals d[STAGES-1] (RESET_VAL after reset/flush).
REQ-023 flush=1: out_val forced 0, in_rdy forced 0, no transfer on either port; next cycle all v=0, all d=RESET_VAL.
REQ-024 reset and flush asserted together: reset behaviour applies.

Reset
REQ-025 reset=0 at posedge: all v cleared, all d set to RESET_VAL, regardless of flush, in_val, out_rdy.
REQ-026 Outputs during/after reset: out_val=0, out_msg=RESET_VAL, in_rdy=1 once reset=1 (0 while reset=0).
REQ-027 Reset mid-operation discards all in-flight messages; no partial transfer is reported.

Configuration
REQ-028 Macro PIPE_REG_OCC_EN: when defined, adds output port occ (width $clog2(STAGES+1)) = count of valid stages, registered, reset to 0, cleared by flush.
REQ-029 occ SHALL update: +1 on enqueue only, -1 on dequeue only, unchanged on both or neither; never exceeds STAGES.
REQ-030 Without PIPE_REG_OCC_EN: occ port and its counter are absent; all other behaviour identical.

Structure
REQ-031 Package pipe_reg_pkg holds default WIDTH/STAGES constants and the occ width function.
REQ-032 Sub-module pipe_reg_stage (one valid bit + WIDTH-bit data register with load enable, reset, flush) instantiated STAGES times via generate.

Verification (WIDTH=8, STAGES=3, RESET_VAL=8'h00 unless noted)
REQ-033 Reset: reset=0 two cycles, then release -> out_val=0, out_msg=8'h00, in_rdy=1, occ=0.
REQ-034 Streaming: send 8'h11,8'h22,8'h33 back-to-back, out_rdy=1 -> outputs appear cycles 3,4,5 in order, occ peaks at 3.
REQ-035 Backpressure: out_rdy=0, send 4 messages -> first 3 accepted, in_rdy=0 on 4th; raise out_rdy -> 4th accepted same cycle 8'h(first) dequeues.
REQ-036 Flush: pipe full with 8'hA1..8'hA3, pulse flush -> next cycle out_val=0, occ=0, out_msg=8'h00; subsequent message has latency 3.
REQ-037 Reset mid-stream: reset=0 while 2 messages in flight -> next cycle empty, no stale message ever emerges.
REQ-038 STAGES=1, RESET_VAL=8'hFF: random val/rdy for 1000 cycles -> scoreboard order match, out_msg=8'hFF after reset.
